// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, frame defaults
// and the running checksum helper.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam logic [7:0]  START_BYTE_DEF   = 8'hA5;
  localparam logic [31:0] BASE_ADDRESS_DEF = 32'h0040_0000;
  localparam int          CHK_WIDTH        = 8;

  // Modulo-256 accumulation of one data byte into the frame checksum.
  function automatic logic [CHK_WIDTH-1:0] chk_add(input logic [CHK_WIDTH-1:0] sum,
                                                   input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, memory write port and status out. The loader uses the
// slave modport; the UART/memory/CPU side uses master.
interface program_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            Byte_i;
  logic                  ByteValid_i;
  logic                  WriteEnable_o;
  logic [DATA_WIDTH-1:0] WriteAddress_o;
  logic [DATA_WIDTH-1:0] WriteData_o;
  logic                  Busy_o;
  logic                  Done_o;
  logic                  Error_o;
  logic                  CpuReset_o;

  modport master (
    output Byte_i, ByteValid_i,
    input  WriteEnable_o, WriteAddress_o, WriteData_o,
    input  Busy_o, Done_o, Error_o, CpuReset_o
  );

  modport slave (
    input  Byte_i, ByteValid_i,
    output WriteEnable_o, WriteAddress_o, WriteData_o,
    output Busy_o, Done_o, Error_o, CpuReset_o
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs accepted bytes big-endian into a word, keeps the running checksum
// and pulses word_done in the cycle after the fourth byte of each word.
module program_loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            data,
  output logic [DATA_WIDTH-1:0] word,
  output logic [1:0]            byte_cnt,
  output logic [CHK_WIDTH-1:0]  sum,
  output logic                  word_done
);

  logic [DATA_WIDTH-1:0] word_r;
  logic [1:0]            cnt_r;
  logic [CHK_WIDTH-1:0]  sum_r;
  logic                  done_r;

  // Shift register, byte counter, checksum and word-complete pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_r <= '0;
      cnt_r  <= 2'd0;
      sum_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (clear) begin
        word_r <= '0;
        cnt_r  <= 2'd0;
        sum_r  <= '0;
      end else if (accept) begin
        word_r <= {word_r[DATA_WIDTH-9:0], data};
        cnt_r  <= cnt_r + 2'd1;
        sum_r  <= chk_add(sum_r, data);
        done_r <= (cnt_r == 2'd3);
      end
    end
  end

  assign word      = word_r;
  assign byte_cnt  = cnt_r;
  assign sum       = sum_r;
  assign word_done = done_r;

endmodule

// File: rtl/program_loader.sv
// Frame parser for the instruction-memory loader: FSM, word/address
// counters and inter-byte timeout; holds the CPU in reset while loading.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH   = 64,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS   = BASE_ADDRESS_DEF,
  parameter logic [7:0]            START_BYTE     = START_BYTE_DEF,
  parameter int                    TIMEOUT_CYCLES = 1000000
) (
  input logic               clk,
  input logic               reset,
  program_loader_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_r, state_s;
  logic [15:0]           len_r, len_s;
  logic [15:0]           word_cnt_r;
  logic [DATA_WIDTH-1:0] addr_r;
  logic [TW-1:0]         idle_cnt_r;
  logic                  busy_r, done_r, error_r, cpu_reset_r;
  logic                  clear_s, accept_s, timeout_s, set_done_s, set_error_s;
  logic [DATA_WIDTH-1:0] asm_word_s;
  logic [1:0]            asm_cnt_s;
  logic [CHK_WIDTH-1:0]  asm_sum_s;
  logic                  asm_done_s;

  program_loader_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .accept    (accept_s),
    .data      (bus.Byte_i),
    .word      (asm_word_s),
    .byte_cnt  (asm_cnt_s),
    .sum       (asm_sum_s),
    .word_done (asm_done_s)
  );

  // ERROR is excluded: it already leaves for IDLE on its own.
  assign timeout_s = (state_r != ST_IDLE) && (state_r != ST_ERROR) && !bus.ByteValid_i &&
                     (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Next-state and per-cycle control decode.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    clear_s     = 1'b0;
    accept_s    = 1'b0;
    set_done_s  = 1'b0;
    set_error_s = 1'b0;
    if (timeout_s) begin
      state_s = ST_ERROR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.ByteValid_i && (bus.Byte_i == START_BYTE)) begin
            clear_s = 1'b1;
            state_s = ST_LEN_HI;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LEN_HI: begin
          if (bus.ByteValid_i) begin
            len_s   = {8'h00, bus.Byte_i};
            state_s = ST_LEN_LO;
          end else begin
            state_s = ST_LEN_HI;
          end
        end
        ST_LEN_LO: begin
          if (bus.ByteValid_i) begin
            len_s = {len_r[7:0], bus.Byte_i};
            if (len_s > 16'(MEMORY_DEPTH)) begin
              state_s = ST_ERROR;
            end else if (len_s == 16'd0) begin
              state_s = ST_CHECK;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            state_s = ST_LEN_LO;
          end
        end
        ST_DATA: begin
          if (bus.ByteValid_i) begin
            accept_s = 1'b1;
            if ((asm_cnt_s == 2'd3) && (word_cnt_r == len_r - 16'd1)) begin
              state_s = ST_CHECK;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_CHECK: begin
          if (bus.ByteValid_i) begin
            if (bus.Byte_i == asm_sum_s) begin
              set_done_s = 1'b1;
            end else begin
              set_error_s = 1'b1;
            end
            state_s = ST_IDLE;
          end else begin
            state_s = ST_CHECK;
          end
        end
        ST_ERROR: begin
          set_error_s = 1'b1;
          state_s     = ST_IDLE;
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      len_r       <= 16'd0;
      word_cnt_r  <= 16'd0;
      addr_r      <= BASE_ADDRESS;
      idle_cnt_r  <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      cpu_reset_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      busy_r      <= (state_s != ST_IDLE);
      cpu_reset_r <= (state_s == ST_IDLE);
      if (clear_s) begin
        done_r  <= 1'b0;
        error_r <= 1'b0;
      end else if (set_done_s) begin
        done_r  <= 1'b1;
        error_r <= 1'b0;
      end else if (set_error_s) begin
        done_r  <= 1'b0;
        error_r <= 1'b1;
      end
      if (clear_s) begin
        word_cnt_r <= 16'd0;
      end else if (accept_s && (asm_cnt_s == 2'd3)) begin
        word_cnt_r <= word_cnt_r + 16'd1;
      end
      // Address advances at the end of the write cycle so it is stable while strobed.
      if (clear_s) begin
        addr_r <= BASE_ADDRESS;
      end else if (asm_done_s) begin
        addr_r <= addr_r + DATA_WIDTH'(4);
      end
      if ((state_s == ST_IDLE) || bus.ByteValid_i) begin
        idle_cnt_r <= '0;
      end else begin
        idle_cnt_r <= idle_cnt_r + TW'(1);
      end
    end
  end

  assign bus.WriteEnable_o  = asm_done_s;
  assign bus.WriteAddress_o = addr_r;
  assign bus.WriteData_o    = asm_word_s;
  assign bus.Busy_o         = busy_r;
  assign bus.Done_o         = done_r;
  assign bus.Error_o        = error_r;
  assign bus.CpuReset_o     = cpu_reset_r;

endmodule
